// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg : opcodes, FSM encoding and default width for alu_sequencer, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

   localparam int unsigned c_default_width = 16;

   localparam logic [3:0] c_op_noop  = 4'd0;
   localparam logic [3:0] c_op_reset = 4'd1;
   localparam logic [3:0] c_op_add   = 4'd2;
   localparam logic [3:0] c_op_sub   = 4'd3;
   localparam logic [3:0] c_op_mult  = 4'd4;
   localparam logic [3:0] c_op_div   = 4'd5;
   localparam logic [3:0] c_op_and   = 4'd6;
   localparam logic [3:0] c_op_or    = 4'd7;
   localparam logic [3:0] c_op_not   = 4'd8;
   localparam logic [3:0] c_op_nor   = 4'd9;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_mul  = 2'd1;
   localparam logic [1:0] c_st_div  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// ----------------------------------------------------------------------------
// alu_iter_unit : shift-add multiplier / restoring divider, one step per clock, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_iter_unit
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = c_default_width,
   parameter int unsigned ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             overflow
);

   localparam int unsigned c_span  = (ITER > WIDTH) ? ITER : WIDTH;
   localparam int unsigned c_cnt_w = $clog2(c_span + 1);
   localparam logic [c_cnt_w-1:0] c_width_cnt = c_cnt_w'(WIDTH);
   localparam logic [c_cnt_w-1:0] c_iter_cnt  = c_cnt_w'(ITER);

   // hi holds the upper product / partial remainder, lo the multiplier / dividend-quotient
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic               op_q, op_d, busy_q, busy_d;
   logic [c_cnt_w-1:0] idx_q, idx_d;

   logic [WIDTH-1:0]   w_hi, w_lo, w_m, w_diff, w_step_hi, w_step_lo;
   logic               w_op;
   logic [c_cnt_w-1:0] w_idx;
   logic [WIDTH:0]     w_sum, w_sh;

   // start performs the first iteration straight from the input operands
   always_comb begin
      if (start) begin
         w_hi  = '0;
         w_op  = op;
         w_idx = '0;
         w_m   = op ? b : a;
         w_lo  = op ? a : b;
      end else begin
         w_hi  = hi_q;
         w_op  = op_q;
         w_idx = idx_q;
         w_m   = m_q;
         w_lo  = lo_q;
      end
      w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_m} : '0);
      w_sh   = {w_hi, w_lo[WIDTH-1]};
      w_diff = w_sh[WIDTH-1:0] - w_m;
      if (w_op) begin
         if (w_sh >= {1'b0, w_m}) begin
            w_step_hi = w_diff;
            w_step_lo = {w_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_step_hi = w_sh[WIDTH-1:0];
            w_step_lo = {w_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_step_hi = w_sum[WIDTH:1];
         w_step_lo = {w_sum[0], w_lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      m_d    = m_q;
      op_d   = op_q;
      idx_d  = idx_q;
      busy_d = busy_q;
      if (start || busy_q) begin
         hi_d = w_hi;
         lo_d = w_lo;
         m_d  = w_m;
         op_d = w_op;
         // iterations past WIDTH hold the finished result
         if (w_idx < c_width_cnt) begin
            hi_d = w_step_hi;
            lo_d = w_step_lo;
         end
         idx_d  = w_idx + 1'b1;
         busy_d = ((w_idx + 1'b1) != c_iter_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         m_q    <= '0;
         op_q   <= 1'b0;
         idx_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         m_q    <= m_d;
         op_q   <= op_d;
         idx_q  <= idx_d;
         busy_q <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign result    = lo_q;
   assign remainder = hi_q;
   assign overflow  = |hi_q;

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer : accumulator ALU, single-cycle logic/arith ops plus iterative MULT/DIV, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = c_default_width,
   parameter int unsigned ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] rem,
   output logic             carry,
   output logic             zero,
   output logic             div0,
   output logic             err,
   output logic             busy,
   output logic             done
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, rem_q, rem_d;
   logic             carry_q, carry_d, zero_q, zero_d;
   logic             div0_q, div0_d, err_q, err_d, done_q, done_d;

   logic             w_accept, w_operand_zero, w_iter_start, w_iter_op;
   logic             w_wr, w_new_carry;
   logic [WIDTH-1:0] w_new_acc;
   logic [WIDTH:0]   w_sum;
   logic             iter_busy, iter_ovf;
   logic [WIDTH-1:0] iter_result, iter_rem;

   assign w_accept       = cmd_valid && cmd_ready;
   assign w_operand_zero = (cmd_operand == '0);
   assign w_iter_op      = (cmd_op == c_op_div);
   assign w_iter_start   = w_accept &&
                           ((cmd_op == c_op_mult) || ((cmd_op == c_op_div) && !w_operand_zero));

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .ITER  (ITER)
   ) u_iter (
      .clk       (clk),
      .rst       (rst),
      .start     (w_iter_start),
      .op        (w_iter_op),
      .a         (acc_q),
      .b         (cmd_operand),
      .busy      (iter_busy),
      .result    (iter_result),
      .remainder (iter_rem),
      .overflow  (iter_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_st_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle: begin
            if (w_accept && (cmd_op == c_op_mult)) begin
               state_d = c_st_mul;
            end else if (w_accept && (cmd_op == c_op_div) && !w_operand_zero) begin
               state_d = c_st_div;
            end
         end
         c_st_mul, c_st_div: begin
            if (!iter_busy) begin
               state_d = c_st_idle;
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_comb begin
      busy      = (state_q == c_st_mul) || (state_q == c_st_div);
      cmd_ready = (state_q == c_st_idle) && !rst;
   end

   always_comb begin
      w_sum       = {1'b0, acc_q} + {1'b0, cmd_operand};
      w_wr        = 1'b0;
      w_new_acc   = acc_q;
      w_new_carry = 1'b0;
      acc_d       = acc_q;
      rem_d       = rem_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      div0_d      = div0_q;
      err_d       = err_q;
      done_d      = 1'b0;
      if (w_accept) begin
         done_d = 1'b1;
         case (cmd_op)
            c_op_noop: ;
            c_op_reset: begin
               acc_d   = '0;
               rem_d   = '0;
               carry_d = 1'b0;
               zero_d  = 1'b1;
               div0_d  = 1'b0;
               err_d   = 1'b0;
            end
            c_op_add: begin
               w_wr        = 1'b1;
               w_new_acc   = w_sum[WIDTH-1:0];
               w_new_carry = w_sum[WIDTH];
            end
            c_op_sub: begin
               w_wr        = 1'b1;
               w_new_acc   = acc_q - cmd_operand;
               w_new_carry = (acc_q < cmd_operand);
            end
            c_op_and: begin
               w_wr      = 1'b1;
               w_new_acc = acc_q & cmd_operand;
            end
            c_op_or: begin
               w_wr      = 1'b1;
               w_new_acc = acc_q | cmd_operand;
            end
            c_op_not: begin
               w_wr      = 1'b1;
               w_new_acc = ~acc_q;
            end
            c_op_nor: begin
               w_wr      = 1'b1;
               w_new_acc = ~(acc_q | cmd_operand);
            end
            c_op_mult: begin
               done_d = 1'b0;
               div0_d = 1'b0;
               err_d  = 1'b0;
            end
            c_op_div: begin
               err_d = 1'b0;
               if (w_operand_zero) begin
                  div0_d = 1'b1;
               end else begin
                  done_d = 1'b0;
                  div0_d = 1'b0;
               end
            end
            default: begin
               err_d  = 1'b1;
               div0_d = 1'b0;
            end
         endcase
         if (w_wr) begin
            acc_d   = w_new_acc;
            carry_d = w_new_carry;
            zero_d  = (w_new_acc == '0);
            div0_d  = 1'b0;
            err_d   = 1'b0;
         end
      end else if (busy && !iter_busy) begin
         // iterative unit finished on the previous edge; retire its result now
         done_d  = 1'b1;
         acc_d   = iter_result;
         zero_d  = (iter_result == '0);
         if (state_q == c_st_mul) begin
            carry_d = iter_ovf;
         end else begin
            carry_d = 1'b0;
            rem_d   = iter_rem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         rem_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         div0_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         div0_q  <= div0_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign acc   = acc_q;
   assign rem   = rem_q;
   assign carry = carry_q;
   assign zero  = zero_q;
   assign div0  = div0_q;
   assign err   = err_q;
   assign done  = done_q;

endmodule

`default_nettype wire
